// File: rtl/alu_8bit.sv
// rtl/alu_8bit.sv - 8-bit, 16-operation ALU with registered result and carry
//
// Purpose:
//   Datapath compute block feeding the result bus. Operands and opcode are
//   sampled on every rising clk edge; result and carry are registered and
//   visible one cycle later. There is no handshake.
//
// Optional build macro:
//   ALU_FLAGS_EN - adds registered Zero and Negative flag outputs.
//
// Ports:
//   clk       in   1  system clock, rising edge
//   rst       in   1  asynchronous active-high reset
//   A         in   8  operand A, unsigned
//   B         in   8  operand B, unsigned
//   ALU_Sel   in   4  operation select
//   ALU_Out   out  8  registered result
//   CarryOut  out  1  registered carry of A+B (reported for every opcode)
//   Zero      out  1  (ALU_FLAGS_EN only) registered ALU_Out == 8'h00
//   Negative  out  1  (ALU_FLAGS_EN only) registered ALU_Out[7]

module alu_8bit (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic [3:0] ALU_Sel,
  output logic [7:0] ALU_Out,
`ifdef ALU_FLAGS_EN
  output logic       Zero,
  output logic       Negative,
`endif
  output logic       CarryOut
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_MUL  = 4'b0010,
    OP_DIV  = 4'b0011,
    OP_SHL  = 4'b0100,
    OP_SHR  = 4'b0101,
    OP_ROL  = 4'b0110,
    OP_ROR  = 4'b0111,
    OP_AND  = 4'b1000,
    OP_OR   = 4'b1001,
    OP_XOR  = 4'b1010,
    OP_NOR  = 4'b1011,
    OP_NAND = 4'b1100,
    OP_XNOR = 4'b1101,
    OP_GT   = 4'b1110,
    OP_EQ   = 4'b1111
  } alu_op_e;

  logic [8:0]  sum9;
  logic [7:0]  diff8;
  logic [15:0] prod16;
  logic [7:0]  divisor;
  logic [7:0]  quot8;
  logic [7:0]  result_d;
  logic        carry_d;

  logic [7:0]  alu_out_q;
  logic        carry_q;

  // Shared arithmetic terms; every opcode reports the carry of A+B.
  assign sum9   = {1'b0, A} + {1'b0, B};
  assign diff8  = A - B;
  assign prod16 = {8'h00, A} * {8'h00, B};

  // Keep the divider away from a zero divisor so no X ever appears; the
  // divide-by-zero case is replaced by 8'hFF in the result mux.
  assign divisor = (B == 8'h00) ? 8'h01 : B;
  assign quot8   = A / divisor;

  assign carry_d = sum9[8];

  always_comb begin
    result_d = 8'h00;
    case (alu_op_e'(ALU_Sel))
      OP_ADD:  result_d = sum9[7:0];
      OP_SUB:  result_d = diff8;
      OP_MUL:  result_d = prod16[7:0];
      OP_DIV:  result_d = (B == 8'h00) ? 8'hFF : quot8;
      OP_SHL:  result_d = {A[6:0], 1'b0};
      OP_SHR:  result_d = {1'b0, A[7:1]};
      OP_ROL:  result_d = {A[6:0], A[7]};
      OP_ROR:  result_d = {A[0], A[7:1]};
      OP_AND:  result_d = A & B;
      OP_OR:   result_d = A | B;
      OP_XOR:  result_d = A ^ B;
      OP_NOR:  result_d = ~(A | B);
      OP_NAND: result_d = ~(A & B);
      OP_XNOR: result_d = ~(A ^ B);
      OP_GT:   result_d = (A > B) ? 8'h01 : 8'h00;
      OP_EQ:   result_d = (A == B) ? 8'h01 : 8'h00;
      default: result_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_out_q <= 8'h00;
      carry_q   <= 1'b0;
    end else begin
      alu_out_q <= result_d;
      carry_q   <= carry_d;
    end
  end

  assign ALU_Out  = alu_out_q;
  assign CarryOut = carry_q;

`ifdef ALU_FLAGS_EN
  logic zero_q;
  logic negative_q;

  // Flags are computed from the next result so they line up with ALU_Out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_q     <= 1'b0;
      negative_q <= 1'b0;
    end else begin
      zero_q     <= (result_d == 8'h00);
      negative_q <= result_d[7];
    end
  end

  assign Zero     = zero_q;
  assign Negative = negative_q;
`endif

endmodule

// File: tb/tb_alu_8bit.sv
// tb/tb_alu_8bit.sv - scoreboard testbench for alu_8bit
module tb_alu_8bit;

  logic       clk;
  logic       rst;
  logic [7:0] A;
  logic [7:0] B;
  logic [3:0] ALU_Sel;
  logic [7:0] ALU_Out;
  logic       CarryOut;
`ifdef ALU_FLAGS_EN
  logic       Zero;
  logic       Negative;
`endif

  alu_8bit dut (
    .clk      (clk),
    .rst      (rst),
    .A        (A),
    .B        (B),
    .ALU_Sel  (ALU_Sel),
    .ALU_Out  (ALU_Out),
`ifdef ALU_FLAGS_EN
    .Zero     (Zero),
    .Negative (Negative),
`endif
    .CarryOut (CarryOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [7:0] out;
    logic       carry;
  } exp_t;

  exp_t sb[$];
  int   n_checks;
  int   n_passed;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Independent reference: arithmetic on integers, bit ops on vectors.
  function automatic logic [7:0] model(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s);
    int ia, ib;
    ia = a;
    ib = b;
    case (s)
      4'h0: return 8'((ia + ib) % 256);
      4'h1: return 8'((ia - ib + 256) % 256);
      4'h2: return 8'((ia * ib) % 256);
      4'h3: return (ib == 0) ? 8'hFF : 8'(ia / ib);
      4'h4: return 8'((ia * 2) % 256);
      4'h5: return 8'(ia / 2);
      4'h6: return 8'(((ia * 2) % 256) + (ia / 128));
      4'h7: return 8'((ia / 2) + ((ia % 2) * 128));
      4'h8: return a & b;
      4'h9: return a | b;
      4'hA: return a ^ b;
      4'hB: return ~(a | b);
      4'hC: return ~(a & b);
      4'hD: return ~(a ^ b);
      4'hE: return (ia > ib) ? 8'h01 : 8'h00;
      default: return (ia == ib) ? 8'h01 : 8'h00;
    endcase
  endfunction

  task automatic compare_head();
    exp_t e;
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check({e.tag, ".out"}, 32'(ALU_Out), 32'(e.out));
    check({e.tag, ".carry"}, 32'(CarryOut), 32'(e.carry));
`ifdef ALU_FLAGS_EN
    check({e.tag, ".zero"}, 32'(Zero), 32'(e.out == 8'h00));
    check({e.tag, ".neg"}, 32'(Negative), 32'(e.out[7]));
`endif
  endtask

  // Drive one vector on the falling edge, after checking the result of the
  // vector driven a cycle earlier.
  task automatic step(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic [3:0] s, input logic [7:0] eo, input logic ec);
    exp_t e;
    @(negedge clk);
    compare_head();
    A = a;
    B = b;
    ALU_Sel = s;
    e.tag = tag;
    e.out = eo;
    e.carry = ec;
    sb.push_back(e);
  endtask

  task automatic flush();
    @(negedge clk);
    compare_head();
  endtask

  logic [7:0] sweep_exp [16];

  initial begin
    n_checks = 0;
    n_passed = 0;
    rst = 1'b1;
    A = 8'h00;
    B = 8'h00;
    ALU_Sel = 4'h0;
    sweep_exp = '{8'hFF, 8'h55, 8'h72, 8'h02, 8'h54, 8'h55, 8'h55, 8'h55,
                  8'h00, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h01, 8'h00};

    A = 8'hFF; B = 8'h01; ALU_Sel = 4'h0;
    repeat (2) @(negedge clk);
    check("reset.out", 32'(ALU_Out), 32'h00);
    check("reset.carry", 32'(CarryOut), 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++)
      step($sformatf("sweep%0h", i), 8'hAA, 8'h55, 4'(i), sweep_exp[i], 1'b0);

    step("add_ff_01", 8'hFF, 8'h01, 4'h0, 8'h00, 1'b1);
    step("sub_ff_01", 8'hFF, 8'h01, 4'h1, 8'hFE, 1'b1);
    step("div_by_0", 8'h37, 8'h00, 4'h3, 8'hFF, 1'b0);
    step("eq_5a", 8'h5A, 8'h5A, 4'hF, 8'h01, 1'b0);
    step("gt_5a", 8'h5A, 8'h5A, 4'hE, 8'h00, 1'b0);
    step("rol_81", 8'h81, 8'h00, 4'h6, 8'h03, 1'b0);
    step("ror_81", 8'h81, 8'h00, 4'h7, 8'hC0, 1'b0);
    step("shl_81", 8'h81, 8'h00, 4'h4, 8'h02, 1'b0);
    step("shr_81", 8'h81, 8'h00, 4'h5, 8'h40, 1'b0);
    step("xor_aa", 8'hAA, 8'hAA, 4'hA, 8'h00, 1'b1);
    step("or_80", 8'h80, 8'h00, 4'h9, 8'h80, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [7:0] ra, rb;
      logic [3:0] rs;
      logic [8:0] rsum;
      ra = 8'($urandom_range(0, 255));
      rb = (i % 8 == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      rs = 4'(i % 16);
      rsum = {1'b0, ra} + {1'b0, rb};
      step($sformatf("rand%0d", i), ra, rb, rs, model(ra, rb, rs), rsum[8]);
    end

    // Mid-operation asynchronous reset with a nonzero result held.
    step("pre_rst", 8'hAA, 8'h55, 4'h0, 8'hFF, 1'b0);
    flush();
    #2 rst = 1'b1;
    #1;
    check("async_rst.out", 32'(ALU_Out), 32'h00);
    check("async_rst.carry", 32'(CarryOut), 32'h0);
    @(negedge clk);
    check("rst_hold.out", 32'(ALU_Out), 32'h00);
    rst = 1'b0;

    step("post_rst", 8'hFF, 8'hFF, 4'h0, 8'hFE, 1'b1);
    flush();

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
